// File: rtl/data_ram.sv
// data_ram: byte-addressable little-endian data memory for the load/store
// port of the memory-access stage. Loads are combinational and stores commit
// on the rising edge. Illegal accesses are suppressed and recorded in a
// sticky fault register. Accepted loads and stores are counted for debug.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_i,
    input  logic [2:0]       mem_size_i,
    input  logic             mem_we_i,
    input  logic             mem_re_i,
    output logic [31:0]      ram_data_o,
    output logic             fault_o,
    output logic [31:0]      fault_addr_o,
    input  logic             fault_clr_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o
);

    localparam int              AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0]     ADDR_LIM  = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]      SZ_B      = 3'b000;
    localparam logic [2:0]      SZ_H      = 3'b001;
    localparam logic [2:0]      SZ_W      = 3'b010;
    localparam logic [2:0]      SZ_BU     = 3'b100;
    localparam logic [2:0]      SZ_HU     = 3'b101;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [AW-1:0]    word_idx_s;
    logic [1:0]       lane_s;
    logic             in_range_s;
    logic             misalign_s;
    logic             bad_size_s;
    logic             illegal_s;
    logic             store_ok_s;
    logic             load_cnt_s;
    logic             load_out_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [31:0]      rd_word_s;
    logic [7:0]       rd_byte_s;
    logic [15:0]      rd_half_s;

    logic             fault_q,      fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0] rd_cnt_q,     rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q,     wr_cnt_d;

    assign word_idx_s = mem_addr_i[AW+1:2];
    assign lane_s     = mem_addr_i[1:0];
    assign in_range_s = (mem_addr_i < ADDR_LIM);

    // Access legality: alignment and size-code checks; stores win over loads.
    always_comb begin
        misalign_s = 1'b0;
        bad_size_s = 1'b0;
        case (mem_size_i)
            SZ_B:    begin misalign_s = 1'b0;                 bad_size_s = 1'b0;     end
            SZ_H:    begin misalign_s = mem_addr_i[0];        bad_size_s = 1'b0;     end
            SZ_W:    begin misalign_s = (lane_s != 2'b00);    bad_size_s = 1'b0;     end
            SZ_BU:   begin misalign_s = 1'b0;                 bad_size_s = mem_we_i; end
            SZ_HU:   begin misalign_s = mem_addr_i[0];        bad_size_s = mem_we_i; end
            default: begin misalign_s = 1'b0;                 bad_size_s = 1'b1;     end
        endcase
        illegal_s  = (mem_we_i | mem_re_i) & (~in_range_s | misalign_s | bad_size_s);
        store_ok_s = mem_we_i & ~illegal_s;
        load_cnt_s = mem_re_i & ~mem_we_i & ~illegal_s;
        load_out_s = mem_re_i & ~illegal_s & rst_n;
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = mem_data_i;
        case (mem_size_i[1:0])
            2'b00: begin
                be_s    = 4'b0001 << lane_s;
                wdata_s = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{mem_data_i[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = mem_data_i;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = mem_data_i;
            end
        endcase
    end

    // Array write; reset low at the edge aborts the store entirely.
    always_ff @(posedge clk) begin
        if (rst_n && store_ok_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Load path: lane select and sign/zero extension, zero when not loading.
    always_comb begin
        rd_word_s  = mem_q[word_idx_s];
        rd_byte_s  = 8'(rd_word_s >> {lane_s, 3'b000});
        rd_half_s  = 16'(rd_word_s >> {lane_s[1], 4'b0000});
        ram_data_o = 32'h0000_0000;
        if (load_out_s) begin
            case (mem_size_i)
                SZ_B:    ram_data_o = {{24{rd_byte_s[7]}}, rd_byte_s};
                SZ_H:    ram_data_o = {{16{rd_half_s[15]}}, rd_half_s};
                SZ_W:    ram_data_o = rd_word_s;
                SZ_BU:   ram_data_o = {24'h00_0000, rd_byte_s};
                SZ_HU:   ram_data_o = {16'h0000, rd_half_s};
                default: ram_data_o = 32'h0000_0000;
            endcase
        end else begin
            ram_data_o = 32'h0000_0000;
        end
    end

    // Next state of the sticky fault record and access counters.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (illegal_s && (!fault_q || fault_clr_i)) begin
            fault_d      = 1'b1;
            fault_addr_d = mem_addr_i;
        end else if (fault_clr_i && !illegal_s) begin
            fault_d      = 1'b0;
        end else begin
            fault_d      = fault_q;
        end
        rd_cnt_d = load_cnt_s ? (rd_cnt_q + CNT_ONE) : rd_cnt_q;
        wr_cnt_d = store_ok_s ? (wr_cnt_q + CNT_ONE) : wr_cnt_q;
    end

    // Fault record and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
            rd_cnt_q     <= {CNT_W{1'b0}};
            wr_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram (16 words, 4-bit counters): byte-array reference model,
// per-cycle compare on the falling edge, directed literal checks, random run.
module tb_data_ram;

    localparam int         DW    = 16;
    localparam int         LIM   = 4 * DW;
    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re, clr;
    logic [31:0] addr, din;
    logic [2:0]  size;
    logic [31:0] ram_data;
    logic        fault;
    logic [31:0] faddr;
    logic [3:0]  rd_cnt, wr_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0]  m_mem [0:LIM-1];
    logic        m_fault;
    logic [31:0] m_faddr;
    int          m_rd, m_wr;

    data_ram #(.DEPTH_WORDS(DW), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr_i   (addr),
        .mem_data_i   (din),
        .mem_size_i   (size),
        .mem_we_i     (we),
        .mem_re_i     (re),
        .ram_data_o   (ram_data),
        .fault_o      (fault),
        .fault_addr_o (faddr),
        .fault_clr_i  (clr),
        .rd_cnt_o     (rd_cnt),
        .wr_cnt_o     (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit mdl_illegal(input logic w, input logic [31:0] a, input logic [2:0] s);
        if (a >= 32'(LIM)) return 1'b1;
        case (s)
            3'd0:    return 1'b0;
            3'd1:    return (a % 2) != 0;
            3'd2:    return (a % 4) != 0;
            3'd4:    return w;
            3'd5:    return w || ((a % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] u;
        case (s)
            3'd0: begin u = 32'(m_mem[a]); if (u >= 32'd128) u = u - 32'd256; end
            3'd4: u = 32'(m_mem[a]);
            3'd1: begin
                u = 32'(m_mem[a]) + 32'd256 * 32'(m_mem[a+1]);
                if (u >= 32'd32768) u = u - 32'd65536;
            end
            3'd5: u = 32'(m_mem[a]) + 32'd256 * 32'(m_mem[a+1]);
            3'd2: u = 32'(m_mem[a]) + 32'd256 * 32'(m_mem[a+1])
                    + 32'd65536 * 32'(m_mem[a+2]) + 32'd16777216 * 32'(m_mem[a+3]);
            default: u = 32'd0;
        endcase
        return u;
    endfunction

    task automatic mdl_reset();
        m_fault = 1'b0;
        m_faddr = 32'd0;
        m_rd    = 0;
        m_wr    = 0;
    endtask

    task automatic mdl_update();
        bit acc, bad;
        acc = we || re;
        bad = acc && mdl_illegal(we, addr, size);
        if (bad && (!m_fault || clr)) begin
            m_fault = 1'b1;
            m_faddr = addr;
        end else if (!bad && clr) begin
            m_fault = 1'b0;
        end
        if (acc && !bad) begin
            if (we) begin
                m_mem[addr] = din[7:0];
                if (size == SZ_H || size == SZ_W) m_mem[addr+1] = din[15:8];
                if (size == SZ_W) begin
                    m_mem[addr+2] = din[23:16];
                    m_mem[addr+3] = din[31:24];
                end
                m_wr = (m_wr + 1) % 16;
            end else begin
                m_rd = (m_rd + 1) % 16;
            end
        end
    endtask

    task automatic set_in(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] s, input logic c);
        we = w; re = r; addr = a; din = d; size = s; clr = c;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) mdl_update();
        #1;
    endtask

    task automatic pulse_rst();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0);
        rst_n = 1'b0;
        mdl_reset();
        step();
        rst_n = 1'b1;
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        exp_rd = (rst_n && re && !mdl_illegal(we, addr, size)) ? mdl_load(addr, size) : 32'd0;
        chk("ram_data", ram_data, exp_rd);
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("fault_addr", faddr, m_faddr);
        chk("rd_cnt", {28'd0, rd_cnt}, 32'(m_rd));
        chk("wr_cnt", {28'd0, wr_cnt}, 32'(m_wr));
    end

    initial begin
        rst_n = 1'b0;
        mdl_reset();
        set_in(1'b0, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0);
        #2;
        chk("reset_ram_data", ram_data, 32'd0);
        chk("reset_fault", {31'd0, fault}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every word so all later loads have known contents
        for (int i = 0; i < DW; i++) begin
            set_in(1'b1, 1'b0, 32'(4 * i), $urandom, SZ_W, 1'b0);
            step();
        end
        pulse_rst();

        // Word store and load
        set_in(1'b1, 1'b0, 32'h10, 32'h12345678, SZ_W, 1'b0); step();
        set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b0); step();
        chk("lw_10", ram_data, 32'h12345678);
        chk("wr_after_sw", {28'd0, wr_cnt}, 32'd1);
        chk("rd_after_lw", {28'd0, rd_cnt}, 32'd1);

        // Byte store, then loads of every width
        set_in(1'b1, 1'b0, 32'h13, 32'h000000A5, SZ_B, 1'b0); step();
        set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b0); step();
        chk("lw_after_sb", ram_data, 32'hA5345678);
        set_in(1'b0, 1'b1, 32'h13, 32'd0, SZ_B, 1'b0); step();
        chk("lb_13", ram_data, 32'hFFFFFFA5);
        set_in(1'b0, 1'b1, 32'h13, 32'd0, SZ_BU, 1'b0); step();
        chk("lbu_13", ram_data, 32'h000000A5);
        set_in(1'b0, 1'b1, 32'h12, 32'd0, SZ_H, 1'b0); step();
        chk("lh_12", ram_data, 32'hFFFFA534);

        // Misaligned halfword store
        set_in(1'b1, 1'b0, 32'h11, 32'h0000BEEF, SZ_H, 1'b0); step();
        chk("sh_mis_fault", {31'd0, fault}, 32'd1);
        chk("sh_mis_faddr", faddr, 32'h11);
        chk("sh_mis_wr", {28'd0, wr_cnt}, 32'd2);
        set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b0); step();
        chk("lw_unchanged", ram_data, 32'hA5345678);

        // First word out of range
        set_in(1'b0, 1'b1, 32'h40, 32'd0, SZ_W, 1'b0); step();
        chk("oor_data", ram_data, 32'd0);
        chk("oor_faddr_held", faddr, 32'h11);
        chk("oor_rd", {28'd0, rd_cnt}, 32'd6);

        // Clear with and without a competing fault
        set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b1); step();
        chk("clr_fault", {31'd0, fault}, 32'd0);
        chk("clr_faddr_kept", faddr, 32'h11);
        set_in(1'b0, 1'b1, 32'h2, 32'd0, SZ_W, 1'b1); step();
        chk("clr_new_fault", {31'd0, fault}, 32'd1);
        chk("clr_new_faddr", faddr, 32'h2);
        set_in(1'b0, 1'b1, 32'h41, 32'd0, SZ_B, 1'b0); step();
        chk("held_faddr", faddr, 32'h2);
        set_in(1'b0, 1'b1, 32'h6, 32'd0, SZ_W, 1'b1); step();
        chk("clr_refault_faddr", faddr, 32'h6);

        // Simultaneous strobes act as a store and read old contents
        set_in(1'b1, 1'b0, 32'h4, 32'h11111111, SZ_W, 1'b0); step();
        set_in(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, SZ_W, 1'b0);
        #2 chk("we_re_old", ram_data, 32'h11111111);
        step();
        chk("we_re_wr", {28'd0, wr_cnt}, 32'd4);
        chk("we_re_rd", {28'd0, rd_cnt}, 32'd7);
        set_in(1'b0, 1'b1, 32'h4, 32'd0, SZ_W, 1'b0); step();
        chk("we_re_new", ram_data, 32'hCAFEF00D);

        // Counter wrap
        pulse_rst();
        repeat (17) begin
            set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b0); step();
        end
        chk("rd_wrap", {28'd0, rd_cnt}, 32'd1);

        // Reset in the middle of a store cycle
        set_in(1'b0, 1'b1, 32'h50, 32'd0, SZ_B, 1'b0); step();
        set_in(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, SZ_W, 1'b0);
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("midrst_rd", {28'd0, rd_cnt}, 32'd0);
        chk("midrst_fault", {31'd0, fault}, 32'd0);
        step();
        rst_n = 1'b1;
        set_in(1'b0, 1'b1, 32'h10, 32'd0, SZ_W, 1'b0);
        #2 chk("midrst_no_write", ram_data, 32'hA5345678);
        step();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] s;
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: s = SZ_B;
                    1: s = SZ_H;
                    2: s = SZ_W;
                    3: s = SZ_BU;
                    default: s = SZ_HU;
                endcase
            end else begin
                s = 3'($urandom_range(0, 7));
            end
            set_in(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, LIM + 7)), $urandom, s,
                   1'($urandom_range(0, 7) == 0));
            step();
        end

        set_in(1'b0, 1'b0, 32'd0, 32'd0, SZ_W, 1'b0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
